// File: rtl/ccff_chain_loader.sv
// Serialises valid/ready bitstream words MSB-first onto a ccff_head configuration chain.
// Define CCFF_LOADER_READBACK_EN to add a VERIFY pass that compares ccff_tail against a replayed stream.
`timescale 1ns/1ps
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 6,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_word_valid,
    output logic              cfg_word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_error
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int CW    = (CNT_W > BIT_W) ? CNT_W : BIT_W;

    localparam logic [CW-1:0] C_LEN  = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] C_WORD = CW'(WORD_W);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef CCFF_LOADER_READBACK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_VERIFY = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t            r_state;
    logic [WORD_W-1:0] r_buf;
    logic [CW-1:0]     r_bits_left;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_fetched;
    logic              r_head;
    logic              r_done;

    logic              w_active;
    logic              w_shift;
    logic              w_last_shift;
    logic              w_ready;
    logic              w_accept;
    logic [CW-1:0]     w_remain;
    logic [CW-1:0]     w_take;

`ifdef CCFF_LOADER_READBACK_EN
    logic              r_error;
    assign w_active  = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign cfg_error = r_error;
`else
    logic              w_unused_tail;
    assign w_active      = (r_state == S_LOAD);
    assign cfg_error     = 1'b0;
    assign w_unused_tail = ccff_tail;
`endif

    // The bit-remaining count is clipped at fetch time, so it alone gates shifting
    // and the partial final word's low bits are never presented.
    assign w_shift      = w_active && (r_bits_left != '0);
    assign w_last_shift = w_shift && (r_cnt == C_LAST);
    assign w_ready      = w_active
                          && ((r_bits_left == '0) || ((r_bits_left == C_ONE) && w_shift))
                          && !w_last_shift
                          && (r_fetched < C_LEN);
    assign w_accept     = w_ready && cfg_word_valid;
    assign w_remain     = C_LEN - r_fetched;
    assign w_take       = (w_remain < C_WORD) ? w_remain : C_WORD;

    assign cfg_word_ready = w_ready;
    assign ccff_shift_en  = w_shift;
    assign ccff_head      = w_shift ? r_buf[WORD_W-1] : r_head;
    assign cfg_busy       = w_active;
    assign cfg_done       = r_done;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_bits_left <= '0;
            r_cnt       <= '0;
            r_fetched   <= '0;
            r_head      <= 1'b0;
            r_done      <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
            r_error     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state     <= S_LOAD;
                        r_buf       <= '0;
                        r_bits_left <= '0;
                        r_cnt       <= '0;
                        r_fetched   <= '0;
`ifdef CCFF_LOADER_READBACK_EN
                        r_error     <= 1'b0;
`endif
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (w_active) begin
                        if (w_shift) begin
                            r_head      <= r_buf[WORD_W-1];
                            r_buf       <= r_buf << 1;
                            r_bits_left <= r_bits_left - C_ONE;
                            r_cnt       <= r_cnt + C_ONE;
                        end
                        // A refill may coincide with the last buffered bit leaving.
                        if (w_accept) begin
                            r_buf       <= cfg_word;
                            r_bits_left <= w_take;
                            r_fetched   <= r_fetched + w_take;
                        end
`ifdef CCFF_LOADER_READBACK_EN
                        if ((r_state == S_VERIFY) && w_shift && (ccff_tail != r_buf[WORD_W-1]))
                            r_error <= 1'b1;
`endif
                        if (w_last_shift) begin
                            r_buf       <= '0;
                            r_bits_left <= '0;
                            r_cnt       <= '0;
                            r_fetched   <= '0;
`ifdef CCFF_LOADER_READBACK_EN
                            if (r_state == S_LOAD) begin
                                r_state <= S_VERIFY;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
`else
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
